// File: rtl/usb_tx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// usb_tx -- full-speed USB packet transmitter (12 Mb/s from a 108 MHz clock)
//
// Sends DATA0/DATA1 packets (sync, PID, payload from a show-ahead FIFO, CRC16)
// and ACK/NAK/STALL handshakes (sync, PID). It NRZI-encodes and bit-stuffs the
// bit stream and finishes every packet with an SE0-SE0-J end-of-packet.
//
// Ports
//   clk                 in   system clock, 108 MHz (one bit period = 9 clocks)
//   rst                 in   synchronous, active-high reset
//   tx_start            in   one-cycle request to send the packet in tx_packet
//   tx_packet[2:0]      in   1=DATA0 2=DATA1 3=ACK 4=NAK 5=STALL, others invalid
//   tx_packet_data[7:0] in   FIFO head byte (show-ahead)
//   buffer_occupancy    in   FIFO byte count, 0..64
//   get_tx_packet_data  out  one-cycle FIFO pop; the head byte is taken that cycle
//   dp_out, dm_out      out  line drive: J=10, K=01, SE0=00
//   tx_transfer_active  out  high from the first sync bit to the last EOP cycle
//   tx_error            out  FIFO underrun; held until the next accepted start
// -----------------------------------------------------------------------------
module usb_tx (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [2:0] tx_packet,
    input  logic [7:0] tx_packet_data,
    input  logic [6:0] buffer_occupancy,
    output logic       get_tx_packet_data,
    output logic       dp_out,
    output logic       dm_out,
    output logic       tx_transfer_active,
    output logic       tx_error
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SYNC    = 3'd1,
        S_PID     = 3'd2,
        S_DATA    = 3'd3,
        S_CRC     = 3'd4,
        S_EOP_SE0 = 3'd5,
        S_EOP_J   = 3'd6
    } state_t;

    localparam logic [2:0]  PKT_DATA0  = 3'd1;
    localparam logic [2:0]  PKT_DATA1  = 3'd2;
    localparam logic [2:0]  PKT_ACK    = 3'd3;
    localparam logic [2:0]  PKT_NAK    = 3'd4;
    localparam logic [2:0]  PKT_STALL  = 3'd5;
    localparam logic [3:0]  BIT_LAST   = 4'd8;     // counter value ending a bit period
    localparam logic [2:0]  STUFF_RUN  = 3'd6;     // ones before a stuffed zero
    localparam logic [15:0] CRC_INIT   = 16'hFFFF;
    localparam logic [15:0] CRC_POLY_R = 16'hA001; // x^16+x^15+x^2+1, bit-reversed

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic logic packet_valid(input logic [2:0] p);
        return (p >= PKT_DATA0) && (p <= PKT_STALL);
    endfunction

    function automatic logic is_data_pkt(input logic [2:0] p);
        return (p == PKT_DATA0) || (p == PKT_DATA1);
    endfunction

    // PID byte is {~pid, pid}; it goes out LSB first like every other field.
    function automatic logic [7:0] pid_byte(input logic [2:0] p);
        logic [3:0] pid;
        unique case (p)
            PKT_DATA0: pid = 4'b0011;
            PKT_DATA1: pid = 4'b1011;
            PKT_ACK:   pid = 4'b0010;
            PKT_NAK:   pid = 4'b1010;
            default:   pid = 4'b1110;
        endcase
        return {~pid, pid};
    endfunction

    // Serial CRC16 with data presented LSB first. Shifting right with the
    // reflected polynomial keeps the remainder in transmit order, so the
    // field is simply ~crc sent from bit 0 upward.
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        return (c[0] ^ b) ? ((c >> 1) ^ CRC_POLY_R) : (c >> 1);
    endfunction

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;    // position within the 9-clock bit period
    logic [3:0]  idx_q,   idx_d;    // bit index in the current field / EOP bit
    logic [2:0]  ones_q,  ones_d;   // consecutive field ones sent
    logic [7:0]  shift_q, shift_d;  // byte being sent (PID or data)
    logic [2:0]  pkt_q,   pkt_d;    // latched packet select
    logic [6:0]  left_q,  left_d;   // data bytes still to load
    logic [15:0] crc_q,   crc_d;
    logic        line_q,  line_d;   // NRZI line level, 1 = J
    logic        se0_q,   se0_d;
    logic        err_q,   err_d;

    // Next-state scratch
    logic       bit_boundary;
    logic       send_en;     // launch a new bit period this cycle
    logic       send_bit;    // its (pre-NRZI) value
    logic       field_bit;   // bit belongs to a stuffed field
    logic       next_byte;   // current byte finished; load the next or move on
    logic       start_eop;
    logic       pop;
    logic [7:0] pid_w;
    logic [2:0] nxt3;
    logic [3:0] nxt4;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            ones_q  <= '0;
            shift_q <= '0;
            pkt_q   <= '0;
            left_q  <= '0;
            crc_q   <= '0;
            line_q  <= 1'b1;
            se0_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            ones_q  <= ones_d;
            shift_q <= shift_d;
            pkt_q   <= pkt_d;
            left_q  <= left_d;
            crc_q   <= crc_d;
            line_q  <= line_d;
            se0_q   <= se0_d;
            err_q   <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Everything happens on the last clock of a bit
    // period: the bit to launch next is chosen here and appears on the line
    // when the counter wraps to 0.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        idx_d     = idx_q;
        ones_d    = ones_q;
        shift_d   = shift_q;
        pkt_d     = pkt_q;
        left_d    = left_q;
        crc_d     = crc_q;
        line_d    = line_q;
        se0_d     = se0_q;
        err_d     = err_q;
        send_en   = 1'b0;
        send_bit  = 1'b0;
        field_bit = 1'b0;
        next_byte = 1'b0;
        start_eop = 1'b0;
        pop       = 1'b0;
        pid_w     = pid_byte(pkt_q);
        nxt3      = idx_q[2:0] + 3'd1;
        nxt4      = idx_q + 4'd1;

        bit_boundary = (cnt_q == BIT_LAST);
        cnt_d        = (state_q == S_IDLE || bit_boundary) ? 4'd0 : cnt_q + 4'd1;

        unique case (state_q)
            S_IDLE: begin
                // Invalid codes are dropped here, leaving the line at J.
                if (tx_start && packet_valid(tx_packet)) begin
                    state_d  = S_SYNC;
                    idx_d    = '0;
                    ones_d   = '0;
                    pkt_d    = tx_packet;
                    left_d   = buffer_occupancy;
                    crc_d    = CRC_INIT;
                    err_d    = 1'b0;
                    send_en  = 1'b1;   // first sync bit (a 0) starts next cycle
                    send_bit = 1'b0;
                end
            end

            S_SYNC: begin
                if (bit_boundary) begin
                    if (idx_q[2:0] != 3'd7) begin
                        idx_d    = {1'b0, nxt3};
                        send_en  = 1'b1;
                        send_bit = (nxt3 == 3'd7);   // sync is 0x80, LSB first
                    end else begin
                        state_d   = S_PID;
                        idx_d     = '0;
                        shift_d   = pid_w;
                        send_en   = 1'b1;
                        field_bit = 1'b1;
                        send_bit  = pid_w[0];
                    end
                end
            end

            S_PID, S_DATA: begin
                if (bit_boundary) begin
                    if (ones_q == STUFF_RUN) begin
                        // Stuffed zero: the field index stays put.
                        send_en   = 1'b1;
                        field_bit = 1'b1;
                        send_bit  = 1'b0;
                    end else if (idx_q[2:0] != 3'd7) begin
                        idx_d     = {1'b0, nxt3};
                        send_en   = 1'b1;
                        field_bit = 1'b1;
                        send_bit  = shift_q[nxt3];
                        if (state_q == S_DATA) begin
                            crc_d = crc_step(crc_q, shift_q[nxt3]);
                        end
                    end else if (state_q == S_PID && !is_data_pkt(pkt_q)) begin
                        start_eop = 1'b1;
                    end else begin
                        next_byte = 1'b1;
                    end
                end
            end

            S_CRC: begin
                if (bit_boundary) begin
                    if (ones_q == STUFF_RUN) begin
                        send_en   = 1'b1;
                        field_bit = 1'b1;
                        send_bit  = 1'b0;
                    end else if (idx_q != 4'd15) begin
                        idx_d     = nxt4;
                        send_en   = 1'b1;
                        field_bit = 1'b1;
                        send_bit  = ~crc_q[nxt4];
                    end else begin
                        start_eop = 1'b1;
                    end
                end
            end

            S_EOP_SE0: begin
                if (bit_boundary) begin
                    if (idx_q == 4'd0) begin
                        idx_d = 4'd1;
                    end else begin
                        state_d = S_EOP_J;
                        idx_d   = '0;
                        se0_d   = 1'b0;
                        line_d  = 1'b1;
                    end
                end
            end

            S_EOP_J: begin
                if (bit_boundary) begin
                    state_d = S_IDLE;
                    line_d  = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                line_d  = 1'b1;
                se0_d   = 1'b0;
            end
        endcase

        // Byte boundary after the PID or a data byte: CRC once the latched
        // count is used up, underrun if the FIFO ran dry early, else load.
        if (next_byte) begin
            idx_d = '0;
            if (left_q == 7'd0) begin
                state_d   = S_CRC;
                send_en   = 1'b1;
                field_bit = 1'b1;
                send_bit  = ~crc_q[0];
            end else if (buffer_occupancy == 7'd0) begin
                err_d     = 1'b1;
                start_eop = 1'b1;
            end else begin
                state_d   = S_DATA;
                pop       = 1'b1;
                shift_d   = tx_packet_data;
                left_d    = left_q - 7'd1;
                send_en   = 1'b1;
                field_bit = 1'b1;
                send_bit  = tx_packet_data[0];
                crc_d     = crc_step(crc_q, tx_packet_data[0]);
            end
        end

        if (start_eop) begin
            state_d = S_EOP_SE0;
            idx_d   = '0;
            se0_d   = 1'b1;
            ones_d  = '0;
        end

        // NRZI: a 0 toggles the line, a 1 holds it.
        if (send_en) begin
            line_d = send_bit ? line_q : ~line_q;
            if (field_bit) begin
                ones_d = send_bit ? ones_q + 3'd1 : 3'd0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        dp_out             = ~se0_q & line_q;
        dm_out             = ~se0_q & ~line_q;
        tx_transfer_active = (state_q != S_IDLE);
        tx_error           = err_q;
        // The pop is combinational so the byte is taken in the same cycle the
        // FIFO is told to advance; a reset cycle must never pop.
        get_tx_packet_data = pop & ~rst;
    end

endmodule

// File: tb/tb_usb_tx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_usb_tx -- self-checking bench for usb_tx
//
// A behavioural model turns packet type and payload bytes into the expected
// line waveform (sync, PID, payload, CRC16, stuffing, NRZI, EOP, one entry per
// clock) plus the expected FIFO pop cycles, and each scenario task compares
// the captured DUT activity against it.
// -----------------------------------------------------------------------------
module tb_usb_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_start;
    logic [2:0] tx_packet;
    logic [7:0] tx_packet_data;
    logic [6:0] buffer_occupancy;
    logic       get_tx_packet_data;
    logic       dp_out;
    logic       dm_out;
    logic       tx_transfer_active;
    logic       tx_error;

    int checks   = 0;
    int failures = 0;

    localparam logic [1:0] SYM_J   = 2'b10;
    localparam logic [1:0] SYM_K   = 2'b01;
    localparam logic [1:0] SYM_SE0 = 2'b00;

    usb_tx dut (
        .clk                (clk),
        .rst                (rst),
        .tx_start           (tx_start),
        .tx_packet          (tx_packet),
        .tx_packet_data     (tx_packet_data),
        .buffer_occupancy   (buffer_occupancy),
        .get_tx_packet_data (get_tx_packet_data),
        .dp_out             (dp_out),
        .dm_out             (dm_out),
        .tx_transfer_active (tx_transfer_active),
        .tx_error           (tx_error)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus payload, FIFO contents and captured activity
    logic [7:0] model_q[$];
    logic [7:0] fifo_q[$];
    logic [7:0] popped_q[$];
    logic [1:0] trace_q[$];
    logic       err_tr_q[$];
    int         pops_q[$];
    bit         first_active;
    bit         timed_out;
    // Expected activity
    logic [1:0] exp_q[$];
    int         exp_pops_q[$];

    function automatic logic [7:0] pid_byte_of(input logic [2:0] pkt);
        logic [3:0] p;
        case (pkt)
            3'd1:    p = 4'b0011;
            3'd2:    p = 4'b1011;
            3'd3:    p = 4'b0010;
            3'd4:    p = 4'b1010;
            default: p = 4'b1110;
        endcase
        return {~p, p};
    endfunction

    // Expected waveform for: sync, PID, first n_bytes of model_q, optional CRC.
    function automatic void build_expected(input logic [7:0] pid_b, input int n_bytes,
                                           input bit with_crc);
        bit          fld[$];
        int          starts[$];
        bit          line_bits[$];
        int          ones;
        int          si;
        logic        lvl;
        logic [15:0] crc;
        exp_q.delete();
        exp_pops_q.delete();
        for (int i = 0; i < 8; i++) line_bits.push_back(i == 7);
        for (int i = 0; i < 8; i++) fld.push_back(pid_b[i]);
        crc = 16'hFFFF;
        for (int k = 0; k < n_bytes; k++) begin
            starts.push_back(fld.size());
            for (int i = 0; i < 8; i++) fld.push_back(model_q[k][i]);
            // byte-wise CRC-16/USB: xor the byte in, then eight reflected shifts
            crc = crc ^ {8'h00, model_q[k]};
            for (int i = 0; i < 8; i++) crc = crc[0] ? ((crc >> 1) ^ 16'hA001) : (crc >> 1);
        end
        crc = ~crc;
        if (with_crc) for (int i = 0; i < 16; i++) fld.push_back(crc[i]);
        ones = 0;
        si   = 0;
        for (int j = 0; j < fld.size(); j++) begin
            if (si < starts.size() && starts[si] == j) begin
                exp_pops_q.push_back(line_bits.size() * 9 - 1);
                si++;
            end
            line_bits.push_back(fld[j]);
            ones = fld[j] ? ones + 1 : 0;
            if (ones == 6) begin
                line_bits.push_back(1'b0);
                ones = 0;
            end
        end
        lvl = 1'b1;
        foreach (line_bits[j]) begin
            if (!line_bits[j]) lvl = ~lvl;
            repeat (9) exp_q.push_back(lvl ? SYM_J : SYM_K);
        end
        repeat (18) exp_q.push_back(SYM_SE0);
        repeat (9)  exp_q.push_back(SYM_J);
    endfunction

    function automatic int first_diff();
        int n = (trace_q.size() < exp_q.size()) ? trace_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (trace_q[i] !== exp_q[i]) return i;
        if (trace_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    function automatic logic [1:0] got_sym(input int i);
        return (i >= 0 && i < trace_q.size()) ? trace_q[i] : 2'b11;
    endfunction

    function automatic logic [1:0] exp_sym(input int i);
        return (i >= 0 && i < exp_q.size()) ? exp_q[i] : 2'b11;
    endfunction

    function automatic bit pops_match();
        if (pops_q.size() != exp_pops_q.size()) return 1'b0;
        foreach (pops_q[i]) if (pops_q[i] != exp_pops_q[i]) return 1'b0;
        return 1'b1;
    endfunction

    // First cycle whose tx_error differs from "0 before se0_at, 1 from se0_at"
    // (se0_at < 0: never set). -1 when all cycles agree.
    function automatic int err_diff(input int se0_at);
        foreach (err_tr_q[i]) begin
            if (err_tr_q[i] !== ((se0_at >= 0) && (i >= se0_at))) return i;
        end
        return -1;
    endfunction

    // Starts a packet from fifo = model_q and records one entry per active
    // clock. uf_after >= 0 forces occupancy to 0 after that many pops;
    // inject_at >= 0 re-asserts tx_start (DATA0) in that active cycle.
    task automatic capture(input logic [2:0] pkt, input int uf_after, input int inject_at);
        bit prev_get = 1'b0;
        bit uf       = (uf_after == 0);
        bit done     = 1'b0;
        trace_q.delete();
        err_tr_q.delete();
        pops_q.delete();
        popped_q.delete();
        first_active = 1'b0;
        timed_out    = 1'b0;
        fifo_q       = model_q;
        tx_packet        = pkt;
        buffer_occupancy = 7'(fifo_q.size());
        tx_packet_data   = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
        tx_start         = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 4000 && !done; c++) begin
            #1;
            tx_start = (c == inject_at);
            if (c == inject_at) tx_packet = 3'd1;
            if (prev_get && fifo_q.size() > 0) begin
                popped_q.push_back(fifo_q.pop_front());
                if (uf_after >= 0 && popped_q.size() >= uf_after) uf = 1'b1;
            end
            buffer_occupancy = uf ? 7'd0 : 7'(fifo_q.size());
            tx_packet_data   = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
            #1;
            if (c == 0) first_active = tx_transfer_active;
            if (!tx_transfer_active) begin
                done = 1'b1;
            end else begin
                trace_q.push_back({dp_out, dm_out});
                err_tr_q.push_back(tx_error);
                if (get_tx_packet_data) pops_q.push_back(c);
                prev_get = get_tx_packet_data;
                @(posedge clk);
            end
        end
        if (!done) begin
            timed_out = 1'b1;
            #2;
        end
        tx_start = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1; tx_start = 1'b0; tx_packet = 3'd0;
        tx_packet_data = 8'h00; buffer_occupancy = 7'd0;
        idle_cycles(3);
        checks++;
        if ({dp_out, dm_out, tx_transfer_active, tx_error, get_tx_packet_data} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_state: dp,dm,active,err,get=%b required 10000",
                     {dp_out, dm_out, tx_transfer_active, tx_error, get_tx_packet_data});
        end
        rst = 1'b0;
        idle_cycles(2);
        checks++;
        if ({dp_out, dm_out, tx_transfer_active} !== 3'b100) begin
            failures++;
            $display("FAIL idle_after_reset: dp,dm,active=%b required 100",
                     {dp_out, dm_out, tx_transfer_active});
        end
    endtask

    task automatic test_ack();
        int d;
        model_q.delete();
        build_expected(8'hD2, 0, 1'b0);
        capture(3'd3, -1, -1);
        checks++;
        if (timed_out || !first_active) begin
            failures++;
            $display("FAIL ack_start: first_active=%0b timeout=%0b required 1/0", first_active, timed_out);
        end
        checks++;
        if (trace_q.size() != 171) begin
            failures++;
            $display("FAIL ack_active_cycles: got %0d required 171", trace_q.size());
        end
        checks++;
        d = first_diff();
        if (d != -1) begin
            failures++;
            $display("FAIL ack_line: cycle %0d got %b required %b", d, got_sym(d), exp_sym(d));
        end
        checks++;
        if (pops_q.size() != 0 || err_diff(-1) != -1) begin
            failures++;
            $display("FAIL ack_pops_err: pops=%0d err_bad_cycle=%0d required 0/-1", pops_q.size(), err_diff(-1));
        end
        idle_cycles(1);
    endtask

    task automatic test_data0_empty();
        int d;
        model_q.delete();
        build_expected(8'hC3, 0, 1'b1);
        capture(3'd1, -1, -1);
        checks++;
        if (trace_q.size() != 315) begin
            failures++;
            $display("FAIL data0_empty_cycles: got %0d required 315", trace_q.size());
        end
        checks++;
        d = first_diff();
        if (d != -1) begin
            failures++;
            $display("FAIL data0_empty_line: cycle %0d got %b required %b", d, got_sym(d), exp_sym(d));
        end
        checks++;
        if (pops_q.size() != 0 || err_diff(-1) != -1) begin
            failures++;
            $display("FAIL data0_empty_pops_err: pops=%0d err_bad_cycle=%0d required 0/-1", pops_q.size(), err_diff(-1));
        end
        idle_cycles(1);
    endtask

    task automatic test_data1_ff();
        int d;
        model_q = '{8'hFF, 8'hFF};
        build_expected(8'h4B, 2, 1'b1);
        capture(3'd2, -1, -1);
        checks++;
        d = first_diff();
        if (d != -1) begin
            failures++;
            $display("FAIL data1_ff_line: cycle %0d got %b required %b", d, got_sym(d), exp_sym(d));
        end
        checks++;
        if (!pops_match()) begin
            failures++;
            $display("FAIL data1_ff_pops: got %0d pops (first at %0d) required %0d (first at %0d)",
                     pops_q.size(), (pops_q.size() > 0) ? pops_q[0] : -1,
                     exp_pops_q.size(), exp_pops_q[0]);
        end
        checks++;
        if (err_diff(-1) != -1) begin
            failures++;
            $display("FAIL data1_ff_err: tx_error set at cycle %0d required never", err_diff(-1));
        end
        idle_cycles(1);
    endtask

    task automatic test_random_packets();
        int         d;
        int         n;
        logic [2:0] pkt;
        for (int it = 0; it < 6; it++) begin
            pkt = 3'($urandom_range(1, 5));
            if (it < 2) pkt = 3'(it + 1);
            n = (pkt <= 3'd2) ? int'($urandom_range(1, 6)) : 0;
            model_q.delete();
            for (int k = 0; k < n; k++) begin
                if (it == 1 && $urandom_range(0, 3) != 0) model_q.push_back(8'hFF);
                else                                      model_q.push_back(8'($urandom));
            end
            build_expected(pid_byte_of(pkt), n, pkt <= 3'd2);
            capture(pkt, -1, -1);
            checks++;
            d = first_diff();
            if (d != -1) begin
                failures++;
                $display("FAIL random_line[%0d] pkt=%0d n=%0d: cycle %0d got %b required %b",
                         it, pkt, n, d, got_sym(d), exp_sym(d));
            end
            checks++;
            if (!pops_match() || err_diff(-1) != -1) begin
                failures++;
                $display("FAIL random_pops[%0d] pkt=%0d: pops %0d required %0d, err_bad_cycle=%0d required -1",
                         it, pkt, pops_q.size(), exp_pops_q.size(), err_diff(-1));
            end
            idle_cycles(1);
        end
    endtask

    task automatic test_underrun();
        int d;
        int se0_at;
        model_q.delete();
        for (int k = 0; k < 4; k++) model_q.push_back(8'($urandom));
        build_expected(8'hC3, 2, 1'b0);
        se0_at = exp_q.size() - 27;
        capture(3'd1, 2, -1);
        checks++;
        d = first_diff();
        if (d != -1) begin
            failures++;
            $display("FAIL underrun_line: cycle %0d got %b required %b", d, got_sym(d), exp_sym(d));
        end
        checks++;
        if (!pops_match()) begin
            failures++;
            $display("FAIL underrun_pops: got %0d pops required %0d", pops_q.size(), exp_pops_q.size());
        end
        checks++;
        d = err_diff(se0_at);
        if (d != -1) begin
            failures++;
            $display("FAIL underrun_err: cycle %0d got %b required set from cycle %0d", d, err_tr_q[d], se0_at);
        end
        idle_cycles(5);
        checks++;
        if (tx_error !== 1'b1) begin
            failures++;
            $display("FAIL underrun_err_hold: tx_error=%b in idle required 1", tx_error);
        end
        // The next accepted start clears the flag from its first cycle.
        model_q.delete();
        build_expected(8'hD2, 0, 1'b0);
        capture(3'd3, -1, -1);
        checks++;
        if (err_tr_q.size() == 0 || err_diff(-1) != -1) begin
            failures++;
            $display("FAIL underrun_err_clear: err_bad_cycle=%0d cycles=%0d required -1", err_diff(-1), err_tr_q.size());
        end
        idle_cycles(1);
    endtask

    task automatic test_reset_mid_data();
        int d;
        tx_packet        = 3'd1;
        buffer_occupancy = 7'd3;
        tx_packet_data   = 8'h12;
        tx_start         = 1'b1;
        @(posedge clk);
        #1 tx_start = 1'b0;
        repeat (230) @(posedge clk);   // lands inside payload byte 1
        #1;
        checks++;
        if (tx_transfer_active !== 1'b1) begin
            failures++;
            $display("FAIL midreset_pre: active=%b before reset required 1", tx_transfer_active);
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({dp_out, dm_out, tx_transfer_active, tx_error} !== 4'b1000) begin
            failures++;
            $display("FAIL midreset_abort: dp,dm,active,err=%b required 1000",
                     {dp_out, dm_out, tx_transfer_active, tx_error});
        end
        idle_cycles(2);
        model_q.delete();
        build_expected(8'h5A, 0, 1'b0);
        capture(3'd4, -1, -1);
        checks++;
        d = first_diff();
        if (d != -1) begin
            failures++;
            $display("FAIL midreset_nak_line: cycle %0d got %b required %b", d, got_sym(d), exp_sym(d));
        end
        idle_cycles(1);
    endtask

    task automatic test_ignored_starts();
        int         d;
        int         bad;
        logic [2:0] codes[3];
        codes = '{3'd0, 3'd6, 3'd7};
        bad   = 0;
        foreach (codes[i]) begin
            tx_packet = codes[i];
            tx_start  = 1'b1;
            @(posedge clk);
            #1 tx_start = 1'b0;
            for (int c = 0; c < 12; c++) begin
                #1;
                if ({dp_out, dm_out, tx_transfer_active} !== 3'b100) bad++;
                @(posedge clk);
                #1;
            end
        end
        #1;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL invalid_code: %0d cycles left idle J, required 0", bad);
        end
        model_q.delete();
        build_expected(8'h5A, 0, 1'b0);
        capture(3'd4, -1, 40);
        checks++;
        d = first_diff();
        if (d != -1 || trace_q.size() != 171) begin
            failures++;
            $display("FAIL restart_during_nak: cycle %0d got %b required %b, cycles %0d required 171",
                     d, got_sym(d), exp_sym(d), trace_q.size());
        end
        idle_cycles(1);
    endtask

    initial begin
        test_reset();
        test_ack();
        test_data0_empty();
        test_data1_ff();
        test_random_packets();
        test_underrun();
        test_reset_mid_data();
        test_ignored_starts();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/usb_tx.md
USB_TX -- requirements
Module: usb_tx

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, 108 MHz.
REQ-002 SHALL have: rst  in  1  reset; one clock; reset is synchronous and active-high.
REQ-003 SHALL have: tx_start  in  1  one-cycle request to send the packet selected by tx_packet.
REQ-004 SHALL have: tx_packet  in  3  packet select: 1=DATA0, 2=DATA1, 3=ACK, 4=NAK, 5=STALL; 0,6,7 are invalid.
REQ-005 SHALL have: tx_packet_data  in  8  FIFO head byte, show-ahead.
REQ-006 SHALL have: buffer_occupancy  in  7  FIFO byte count, 0..64.
REQ-007 SHALL have: get_tx_packet_data  out  1  one-cycle FIFO pop.
REQ-008 SHALL have: dp_out, dm_out  out  1 each  USB line drive.
REQ-009 SHALL have: tx_transfer_active  out  1  high from the first sync bit through the last EOP cycle.
REQ-010 SHALL have: tx_error  out  1  FIFO underrun flag.

Function
REQ-011 SHALL use a bit period of exactly 9 clk cycles (12 Mb/s), with a counter 0..8; the line value changes only when the counter wraps.
REQ-012 SHALL drive idle J (dp_out=1, dm_out=0) when not transmitting.
REQ-013 SHALL provide states IDLE, SYNC, PID, DATA, CRC, EOP_SE0, EOP_J.
- IDLE -> SYNC on tx_start with a valid tx_packet.
- SYNC -> PID -> DATA (data packets) or EOP_SE0 (handshake packets).
- DATA -> CRC -> EOP_SE0 -> EOP_J -> IDLE.
REQ-014 SHALL latch tx_packet and buffer_occupancy (byte count N) on the accepted tx_start cycle.
REQ-015 SHALL drive the first sync bit in the cycle after the accepted tx_start, with tx_transfer_active rising in that same cycle.
REQ-016 SHALL ignore tx_start while active, and SHALL ignore invalid tx_packet codes (no output change).
REQ-017 SHALL send sync byte 0x80 LSB first (seven 0 bits, then one 1 bit).
REQ-018 SHALL send the PID byte as {~pid[3:0], pid[3:0]}, LSB first.
- PID values: DATA0=0011, DATA1=1011, ACK=0010, NAK=1010, STALL=1110.
REQ-019 SHALL NRZI-encode every bit after sync start: a 0 bit toggles the line (J<->K); a 1 bit holds it. K is dp_out=0, dm_out=1.
REQ-020 SHALL bit-stuff: after six consecutive 1 data bits it inserts a 0 bit period.
- The ones counter resets on any 0, including stuffed zeros.
- A stuffed bit does not advance the data bit index.
- Stuffing applies to the PID, DATA and CRC fields.
REQ-021 SHALL pulse get_tx_packet_data for one cycle when each data byte is loaded, sampling tx_packet_data in that cycle. A load occurs on the bit-period boundary that starts the byte's first bit. There are exactly N pulses per packet.
REQ-022 SHALL accept N=0, going directly from PID to CRC.
REQ-023 SHALL compute CRC16 over data bytes, LSB first.
- Polynomial x^16+x^15+x^2+1, initial value 0xFFFF.
- Transmits the ones-complement of the remainder, LSB first.
- Resulting field for N=0 is 0x0000.
REQ-024 SHALL drive EOP as SE0 (dp_out=0, dm_out=0) for 2 bit periods (18 cycles), then J for 1 bit period (9 cycles), then return to IDLE.
REQ-025 SHALL drop tx_transfer_active in the first IDLE cycle.
REQ-026 Underrun: if buffer_occupancy==0 when a data byte load is due, the block SHALL:
- not pulse get_tx_packet_data;
- set tx_error;
- skip CRC and enter EOP_SE0 at the next bit boundary.
REQ-027 SHALL hold tx_error until the next accepted tx_start, which clears it.

Reset
REQ-028 While rst=1 at a rising clk edge, the block SHALL:
- enter IDLE;
- set dp_out=1, dm_out=0, tx_transfer_active=0, tx_error=0, get_tx_packet_data=0;
- clear the bit counter, ones counter and CRC register.
REQ-029 Reset asserted mid-packet SHALL abort the packet at the next edge with no EOP; the next tx_start after reset SHALL behave normally.

Verification
REQ-030 ACK: tx_start with tx_packet=3 -> 8 sync + 8 PID (0xD2) bits + EOP.
- tx_transfer_active is high for exactly 171 cycles.
- No get_tx_packet_data pulses.
- Line decodes (after NRZI) to 0x80, 0xD2.
REQ-031 DATA0 with N=0: tx_start with tx_packet=1 and buffer_occupancy=0 -> PID byte 0xC3, CRC field 0x0000.
- 315 active cycles.
- No pops, tx_error=0.
REQ-032 DATA1 with N=2, bytes 0xFF,0xFF -> exactly 2 pops, each 72 cycles apart unless a stuffed bit intervenes.
- Stuffed 0 bits inserted after every six 1s.
- CRC field equals the complemented CRC16 of {0xFF,0xFF}.
- Decoded payload after destuffing equals 0xFF,0xFF.
REQ-033 Underrun: N=4 latched, buffer_occupancy forced to 0 after 2 pops -> 2 pops only.
- tx_error=1 at the third byte boundary.
- SE0 for 18 cycles follows.
- tx_error stays 1 in IDLE until the next tx_start.
REQ-034 Reset mid-DATA: rst pulsed during byte 1 -> next cycle J, tx_transfer_active=0; a following NAK transmits cleanly (PID 0x5A).
REQ-035 tx_start with tx_packet=6, and a second tx_start during an active NAK -> both ignored; the NAK's timing is unchanged.
